// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin sharing of one DRAM block port between the
//             instruction-cache and data-cache refill/write-back paths.
//  Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

module mem_arbiter #(
    parameter int ADDR_W      = `DRAM_ADDRESS_SIZE,
    parameter int WORD_W      = `DRAM_WORD_SIZE,
    parameter int BLOCK_WORDS = `DRAM_BLOCK_SIZE,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             icache_mem_address,
    input  logic                          icache_mem_valid,
    output logic [WORD_W*BLOCK_WORDS-1:0] icache_mem_data_in,
    output logic                          icache_mem_ready,
    input  logic [ADDR_W-1:0]             dcache_mem_address,
    input  logic                          dcache_mem_valid,
    input  logic                          dcache_mem_rw,
    input  logic [WORD_W*BLOCK_WORDS-1:0] dcache_mem_data_out,
    output logic [WORD_W*BLOCK_WORDS-1:0] dcache_mem_data_in,
    output logic                          dcache_mem_ready,
    output logic [ADDR_W-1:0]             dram_address,
    output logic                          dram_valid,
    output logic                          dram_rw,
    output logic [WORD_W*BLOCK_WORDS-1:0] dram_data_write,
    input  logic [WORD_W*BLOCK_WORDS-1:0] dram_data_read,
    input  logic                          dram_ready,
    output logic                          arb_busy,
    output logic                          arb_error
);

    localparam int c_blk_w = WORD_W * BLOCK_WORDS;
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_tmo    = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_tmo_m1 = c_cnt_w'(TIMEOUT - 1);
    localparam logic c_own_ic = 1'b0;
    localparam logic c_own_dc = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 ic_pend_q, ic_pend_d;
    logic                 dc_pend_q, dc_pend_d;
    logic [ADDR_W-1:0]    ic_addr_q, ic_addr_d;
    logic [ADDR_W-1:0]    dc_addr_q, dc_addr_d;
    logic                 dc_rw_q, dc_rw_d;
    logic [c_blk_w-1:0]   dc_wdata_q, dc_wdata_d;
    logic                 last_grant_q, last_grant_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [ADDR_W-1:0]    dram_addr_q, dram_addr_d;
    logic                 dram_valid_q, dram_valid_d;
    logic                 dram_rw_q, dram_rw_d;
    logic [c_blk_w-1:0]   dram_wdata_q, dram_wdata_d;
    logic [c_blk_w-1:0]   ic_rdata_q, ic_rdata_d;
    logic [c_blk_w-1:0]   dc_rdata_q, dc_rdata_d;
    logic                 ic_ready_q, ic_ready_d;
    logic                 dc_ready_q, dc_ready_d;
    logic                 w_grant_dc;

    always_comb begin
        state_d      = state_q;
        ic_pend_d    = ic_pend_q;
        dc_pend_d    = dc_pend_q;
        ic_addr_d    = ic_addr_q;
        dc_addr_d    = dc_addr_q;
        dc_rw_d      = dc_rw_q;
        dc_wdata_d   = dc_wdata_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        dram_addr_d  = dram_addr_q;
        dram_valid_d = 1'b0;
        dram_rw_d    = dram_rw_q;
        dram_wdata_d = dram_wdata_q;
        ic_rdata_d   = ic_rdata_q;
        dc_rdata_d   = dc_rdata_q;
        ic_ready_d   = 1'b0;
        dc_ready_d   = 1'b0;
        w_grant_dc   = 1'b0;

        // A repeated pulse from a requester that is still pending is dropped.
        if (icache_mem_valid) begin
            if (ic_pend_q) begin
                err_d = 1'b1;
            end else begin
                ic_pend_d = 1'b1;
                ic_addr_d = icache_mem_address;
            end
        end
        if (dcache_mem_valid) begin
            if (dc_pend_q) begin
                err_d = 1'b1;
            end else begin
                dc_pend_d  = 1'b1;
                dc_addr_d  = dcache_mem_address;
                dc_rw_d    = dcache_mem_rw;
                dc_wdata_d = dcache_mem_data_out;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ic_pend_q || dc_pend_q) begin
                    w_grant_dc   = dc_pend_q && (!ic_pend_q || (last_grant_q == c_own_ic));
                    dram_addr_d  = w_grant_dc ? dc_addr_q : ic_addr_q;
                    dram_rw_d    = w_grant_dc & dc_rw_q;
                    dram_wdata_d = w_grant_dc ? dc_wdata_q : '0;
                    dram_valid_d = 1'b1;
                    last_grant_d = w_grant_dc ? c_own_dc : c_own_ic;
                    cnt_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dram_ready) begin
                    if (last_grant_q == c_own_dc) begin
                        dc_ready_d = 1'b1;
                        dc_pend_d  = 1'b0;
                        if (!dc_rw_q) begin
                            dc_rdata_d = dram_data_read;
                        end
                    end else begin
                        ic_ready_d = 1'b1;
                        ic_pend_d  = 1'b0;
                        ic_rdata_d = dram_data_read;
                    end
                    state_d = ST_IDLE;
                end else if (cnt_q != c_tmo) begin
                    // Counter saturates at TIMEOUT; the flag rises as it gets there.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_tmo_m1) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ic_pend_q    <= 1'b0;
            dc_pend_q    <= 1'b0;
            ic_addr_q    <= '0;
            dc_addr_q    <= '0;
            dc_rw_q      <= 1'b0;
            dc_wdata_q   <= '0;
            last_grant_q <= c_own_dc;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            dram_addr_q  <= '0;
            dram_valid_q <= 1'b0;
            dram_rw_q    <= 1'b0;
            dram_wdata_q <= '0;
            ic_rdata_q   <= '0;
            dc_rdata_q   <= '0;
            ic_ready_q   <= 1'b0;
            dc_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ic_pend_q    <= ic_pend_d;
            dc_pend_q    <= dc_pend_d;
            ic_addr_q    <= ic_addr_d;
            dc_addr_q    <= dc_addr_d;
            dc_rw_q      <= dc_rw_d;
            dc_wdata_q   <= dc_wdata_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            dram_addr_q  <= dram_addr_d;
            dram_valid_q <= dram_valid_d;
            dram_rw_q    <= dram_rw_d;
            dram_wdata_q <= dram_wdata_d;
            ic_rdata_q   <= ic_rdata_d;
            dc_rdata_q   <= dc_rdata_d;
            ic_ready_q   <= ic_ready_d;
            dc_ready_q   <= dc_ready_d;
        end
    end

    assign icache_mem_data_in = ic_rdata_q;
    assign icache_mem_ready   = ic_ready_q;
    assign dcache_mem_data_in = dc_rdata_q;
    assign dcache_mem_ready   = dc_ready_q;
    assign dram_address       = dram_addr_q;
    assign dram_valid         = dram_valid_q;
    assign dram_rw            = dram_rw_q;
    assign dram_data_write    = dram_wdata_q;
    assign arb_busy           = (state_q == ST_WAIT);
    assign arb_error          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int BW = 4;
    localparam int DW = WW * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ic_addr;
    logic          ic_valid;
    logic [DW-1:0] ic_data_in;
    logic          ic_ready;
    logic [AW-1:0] dc_addr;
    logic          dc_valid;
    logic          dc_rw;
    logic [DW-1:0] dc_data_out;
    logic [DW-1:0] dc_data_in;
    logic          dc_ready;
    logic [AW-1:0] dram_address;
    logic          dram_valid;
    logic          dram_rw;
    logic [DW-1:0] dram_data_write;
    logic [DW-1:0] dram_data_read;
    logic          dram_ready;
    logic          arb_busy;
    logic          arb_error;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW), .TIMEOUT(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .icache_mem_address (ic_addr),
        .icache_mem_valid   (ic_valid),
        .icache_mem_data_in (ic_data_in),
        .icache_mem_ready   (ic_ready),
        .dcache_mem_address (dc_addr),
        .dcache_mem_valid   (dc_valid),
        .dcache_mem_rw      (dc_rw),
        .dcache_mem_data_out(dc_data_out),
        .dcache_mem_data_in (dc_data_in),
        .dcache_mem_ready   (dc_ready),
        .dram_address       (dram_address),
        .dram_valid         (dram_valid),
        .dram_rw            (dram_rw),
        .dram_data_write    (dram_data_write),
        .dram_data_read     (dram_data_read),
        .dram_ready         (dram_ready),
        .arb_busy           (arb_busy),
        .arb_error          (arb_error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Word 0 of a block sits in the least-significant bits.
    function automatic logic [DW-1:0] blk(input logic [31:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ic_addr = '0; ic_valid = 1'b0;
        dc_addr = '0; dc_valid = 1'b0; dc_rw = 1'b0; dc_data_out = '0;
        dram_data_read = '0; dram_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({dram_valid, dram_rw, ic_ready, dc_ready, arb_busy, arb_error} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                {dram_valid, dram_rw, ic_ready, dc_ready, arb_busy, arb_error});
        end
        checks++;
        if ({dram_address, dram_data_write, ic_data_in, dc_data_in} !== '0) begin
            errors++; $display("FAIL reset_data: got addr=%h wdata=%h ic=%h dc=%h expected all zero",
                dram_address, dram_data_write, ic_data_in, dc_data_in);
        end
        do_reset();
    endtask

    task automatic test_icache_read();
        do_reset();
        ic_valid = 1'b1; ic_addr = 32'h100;            // cycle 0
        tick(); ic_valid = 1'b0;                       // cycle 1
        checks++;
        if (dram_valid !== 1'b0) begin errors++; $display("FAIL ic_dv_c1: got %b expected 0", dram_valid); end
        tick();                                        // cycle 2
        checks++;
        if ({dram_valid, dram_rw, dram_address, arb_busy} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
            errors++; $display("FAIL ic_issue: got dv=%b rw=%b addr=%h busy=%b expected 1 0 00000100 1",
                dram_valid, dram_rw, dram_address, arb_busy);
        end
        tick();                                        // cycle 3
        checks++;
        if (dram_valid !== 1'b0) begin errors++; $display("FAIL ic_dv_c3: got %b expected 0", dram_valid); end
        tick();                                        // cycle 4
        tick();                                        // cycle 5
        dram_ready = 1'b1; dram_data_read = blk(1, 2, 3, 4);
        checks++;
        if (ic_ready !== 1'b0) begin errors++; $display("FAIL ic_early_ready: got %b expected 0", ic_ready); end
        tick(); dram_ready = 1'b0;                     // cycle 6
        checks++;
        if ({ic_ready, dc_ready, arb_busy} !== 3'b100 || ic_data_in !== blk(1, 2, 3, 4)) begin
            errors++; $display("FAIL ic_done: got ir=%b dr=%b busy=%b data=%h expected 1 0 0 %h",
                ic_ready, dc_ready, arb_busy, ic_data_in, blk(1, 2, 3, 4));
        end
        tick();                                        // cycle 7
        checks++;
        if (ic_ready !== 1'b0) begin errors++; $display("FAIL ic_ready_pulse: got %b expected 0", ic_ready); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ic_valid = 1'b1; ic_addr = 32'h40;
        dc_valid = 1'b1; dc_addr = 32'h80; dc_rw = 1'b0;           // cycle 0
        tick(); ic_valid = 1'b0; dc_valid = 1'b0;                 // cycle 1
        tick();                                                   // cycle 2
        checks++;
        if ({dram_valid, dram_rw, dram_address} !== {1'b1, 1'b0, 32'h40}) begin
            errors++; $display("FAIL tie1_first: got dv=%b rw=%b addr=%h expected 1 0 00000040",
                dram_valid, dram_rw, dram_address);
        end
        dram_ready = 1'b1; dram_data_read = blk(5, 6, 7, 8);
        tick(); dram_ready = 1'b0;                                // cycle 3
        checks++;
        if ({ic_ready, dc_ready, dram_valid} !== 3'b100 || ic_data_in !== blk(5, 6, 7, 8)) begin
            errors++; $display("FAIL tie1_ic_done: got ir=%b dr=%b dv=%b data=%h expected 1 0 0 %h",
                ic_ready, dc_ready, dram_valid, ic_data_in, blk(5, 6, 7, 8));
        end
        tick();                                                   // cycle 4
        checks++;
        if ({dram_valid, dram_address} !== {1'b1, 32'h80}) begin
            errors++; $display("FAIL tie1_second: got dv=%b addr=%h expected 1 00000080", dram_valid, dram_address);
        end
        dram_ready = 1'b1; dram_data_read = blk(9, 10, 11, 12);
        tick(); dram_ready = 1'b0;                                // cycle 5
        checks++;
        if ({dc_ready, ic_ready} !== 2'b10 || dc_data_in !== blk(9, 10, 11, 12)) begin
            errors++; $display("FAIL tie1_dc_done: got dr=%b ir=%b data=%h expected 1 0 %h",
                dc_ready, ic_ready, dc_data_in, blk(9, 10, 11, 12));
        end
        ic_valid = 1'b1; ic_addr = 32'h48;                        // lone icache
        tick(); ic_valid = 1'b0;                                  // cycle 6
        tick();                                                   // cycle 7
        dram_ready = 1'b1; dram_data_read = blk(13, 14, 15, 16);
        tick(); dram_ready = 1'b0;                                // cycle 8: ic ready
        ic_valid = 1'b1; ic_addr = 32'h4C;
        dc_valid = 1'b1; dc_addr = 32'h8C;
        tick(); ic_valid = 1'b0; dc_valid = 1'b0;                 // cycle 9
        tick();                                                   // cycle 10
        checks++;
        if ({dram_valid, dram_address} !== {1'b1, 32'h8C}) begin
            errors++; $display("FAIL tie2_dc_first: got dv=%b addr=%h expected 1 0000008c", dram_valid, dram_address);
        end
        dram_ready = 1'b1; dram_data_read = blk(17, 18, 19, 20);
        tick(); dram_ready = 1'b0;                                // cycle 11
        tick();                                                   // cycle 12
        checks++;
        if ({dram_valid, dram_address} !== {1'b1, 32'h4C}) begin
            errors++; $display("FAIL tie2_ic_second: got dv=%b addr=%h expected 1 0000004c", dram_valid, dram_address);
        end
        dram_ready = 1'b1; dram_data_read = blk(21, 22, 23, 24);
        tick(); dram_ready = 1'b0;                                // cycle 13
        checks++;
        if (ic_ready !== 1'b1 || ic_data_in !== blk(21, 22, 23, 24) || arb_error !== 1'b0) begin
            errors++; $display("FAIL tie2_ic_done: got ir=%b data=%h err=%b expected 1 %h 0",
                ic_ready, ic_data_in, arb_error, blk(21, 22, 23, 24));
        end
    endtask

    // Continues from test_simultaneous: dcache data_in holds blk(17..20).
    task automatic test_writeback();
        dc_valid = 1'b1; dc_rw = 1'b1; dc_addr = 32'h200;
        dc_data_out = blk(32'hA, 32'hB, 32'hC, 32'hD);
        tick(); dc_valid = 1'b0; dc_rw = 1'b0; dc_data_out = '0;
        dram_data_read = blk(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D);
        tick();
        checks++;
        if ({dram_valid, dram_rw, dram_address} !== {1'b1, 1'b1, 32'h200} ||
            dram_data_write !== blk(32'hA, 32'hB, 32'hC, 32'hD)) begin
            errors++; $display("FAIL wb_issue: got dv=%b rw=%b addr=%h wdata=%h expected 1 1 00000200 %h",
                dram_valid, dram_rw, dram_address, dram_data_write, blk(32'hA, 32'hB, 32'hC, 32'hD));
        end
        dram_ready = 1'b1;
        tick(); dram_ready = 1'b0;
        checks++;
        if ({dc_ready, ic_ready} !== 2'b10 || dc_data_in !== blk(17, 18, 19, 20)) begin
            errors++; $display("FAIL wb_done: got dr=%b ir=%b data=%h expected 1 0 %h",
                dc_ready, ic_ready, dc_data_in, blk(17, 18, 19, 20));
        end
        checks++;
        if (dram_address !== 32'h200 || dram_rw !== 1'b1) begin
            errors++; $display("FAIL wb_hold: got addr=%h rw=%b expected 00000200 1", dram_address, dram_rw);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        ic_valid = 1'b1; ic_addr = 32'h100;
        tick(); ic_addr = 32'h999;
        tick(); ic_valid = 1'b0;
        checks++;
        if ({arb_error, dram_valid, dram_address} !== {1'b1, 1'b1, 32'h100}) begin
            errors++; $display("FAIL proto_issue: got err=%b dv=%b addr=%h expected 1 1 00000100",
                arb_error, dram_valid, dram_address);
        end
        dram_ready = 1'b1; dram_data_read = blk(7, 7, 7, 7);
        tick(); dram_ready = 1'b0;
        tick();
        checks++;
        if (dram_valid !== 1'b0) begin errors++; $display("FAIL proto_no_reissue: got dv=%b expected 0", dram_valid); end
        tick();
        checks++;
        if ({dram_valid, arb_busy, arb_error} !== 3'b001) begin
            errors++; $display("FAIL proto_idle: got dv=%b busy=%b err=%b expected 0 0 1", dram_valid, arb_busy, arb_error);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ic_valid = 1'b1; ic_addr = 32'h300;                        // cycle 0
        tick(); ic_valid = 1'b0;                                   // cycle 1
        repeat (8) tick();                                         // cycle 9
        checks++;
        if (arb_error !== 1'b0) begin errors++; $display("FAIL tmo_early: got err=%b expected 0", arb_error); end
        tick();                                                    // cycle 10
        checks++;
        if ({arb_error, arb_busy} !== 2'b11) begin
            errors++; $display("FAIL tmo_set: got err=%b busy=%b expected 1 1", arb_error, arb_busy);
        end
        repeat (5) tick();
        dram_ready = 1'b1; dram_data_read = blk(40, 41, 42, 43);
        tick(); dram_ready = 1'b0;
        checks++;
        if ({ic_ready, arb_error} !== 2'b11 || ic_data_in !== blk(40, 41, 42, 43)) begin
            errors++; $display("FAIL tmo_done: got ir=%b err=%b data=%h expected 1 1 %h",
                ic_ready, arb_error, ic_data_in, blk(40, 41, 42, 43));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ic_valid = 1'b1; ic_addr = 32'h100;
        tick();                                 // repeated pulse raises arb_error
        tick(); ic_valid = 1'b0;
        tick();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({dram_valid, dram_rw, arb_busy, arb_error, ic_ready, dc_ready} !== 6'b0 || dram_address !== '0) begin
            errors++; $display("FAIL areset_outs: got dv=%b rw=%b busy=%b err=%b ir=%b dr=%b addr=%h expected all 0",
                dram_valid, dram_rw, arb_busy, arb_error, ic_ready, dc_ready, dram_address);
        end
        @(negedge clk); reset = 1'b0;
        dram_ready = 1'b1; dram_data_read = blk(50, 51, 52, 53);
        tick(); dram_ready = 1'b0;
        tick();
        checks++;
        if ({ic_ready, dc_ready, arb_busy, dram_valid} !== 4'b0 || ic_data_in !== '0) begin
            errors++; $display("FAIL areset_ignore: got ir=%b dr=%b busy=%b dv=%b data=%h expected 0 0 0 0 0",
                ic_ready, dc_ready, arb_busy, dram_valid, ic_data_in);
        end
    endtask

    initial begin
        reset = 1'b1;
        ic_addr = '0; ic_valid = 1'b0;
        dc_addr = '0; dc_valid = 1'b0; dc_rw = 1'b0; dc_data_out = '0;
        dram_data_read = '0; dram_ready = 1'b0;
        test_reset();
        test_icache_read();
        test_simultaneous();
        test_writeback();
        test_protocol();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
